// File: rtl/hfrv_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized line, mid-bit sampling FSM and
// a first-word-fall-through receive FIFO with sticky overflow.
module hfrv_uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          framing_err,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [2:0]                    dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    logic           r_sync1;
    logic           r_sync2;
    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_idx;
    logic [7:0]     r_shift;
    logic           r_framing_err;
    logic           r_overflow;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [LW-1:0]  r_level;
    logic [7:0]     r_out_data;

    logic           w_rxs;
    state_t         w_state_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [2:0]     w_idx_nxt;
    logic [7:0]     w_shift_nxt;
    logic           w_push;
    logic           w_ferr;
    logic           w_pop;
    logic           w_full;
    logic           w_wr;
    logic           w_ovf_set;
    logic [LW-1:0]  w_level_nxt;
    logic [AW-1:0]  w_rptr_nxt;
    logic [7:0]     w_head_nxt;

    assign w_rxs = r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_framing_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_shift       <= w_shift_nxt;
            r_framing_err <= w_ferr;
        end
    end

    // Counter only decrements while non-zero; every zero is a sample point.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = HALF_BIT;
                end
            end
            S_START: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!w_rxs) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = FULL_BIT;
                    w_idx_nxt   = 3'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_shift_nxt[r_idx] = w_rxs;
                    w_cnt_nxt          = FULL_BIT;
                    w_idx_nxt          = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_rxs) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ferr      = 1'b1;
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (w_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake: a byte leaves the FIFO on any cycle where out_valid and
    // out_ready are both high; out_ready with out_valid low has no effect.
    assign w_pop       = out_ready && (r_level != '0);
    assign w_full      = (r_level == LW'(FIFO_DEPTH));
    assign w_wr        = w_push && (!w_full || w_pop);
    assign w_ovf_set   = w_push && w_full && !w_pop;
    assign w_level_nxt = r_level + LW'(w_wr) - LW'(w_pop);
    assign w_rptr_nxt  = w_pop ? r_rptr + AW'(1) : r_rptr;

    // The new head is the incoming byte only when it becomes the sole entry.
    assign w_head_nxt  = (w_wr && (w_level_nxt == LW'(1))) ? r_shift : r_mem[w_rptr_nxt];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_out_data <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            r_rptr  <= w_rptr_nxt;
            r_level <= w_level_nxt;
            if (w_level_nxt != '0) begin
                r_out_data <= w_head_nxt;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = (r_level != '0);
    assign level       = r_level;
    assign busy        = (r_state != S_IDLE);
    assign framing_err = r_framing_err;
    assign overflow    = r_overflow;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_hfrv_uart_rx.sv
// Bench for hfrv_uart_rx: frame-level driver, queue-based receive model with
// frame timing arithmetic, per-cycle compare and directed literal checks.
module tb_hfrv_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int LW    = 4;
    // Bit-time arithmetic from the frame start edge (posedge P before rx falls):
    // 2 sync cycles + 1 detect, half bit to mid start, 9 more bits to mid stop.
    localparam int PUSH_LAT = 3 + (CPB / 2 - 1) + 1 + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       rx = 1'b1;
    logic       out_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       framing_err;
    logic       overflow;
    logic [LW-1:0] level;
    logic [2:0] dbg_state;

    hfrv_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .framing_err  (framing_err),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .level        (level),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [7:0] b;
        bit         good;
    } ev_t;

    int         checks = 0;
    int         errors = 0;
    ev_t        pend[$];
    logic [7:0] exp_q[$];
    logic [7:0] popped[$];
    logic [7:0] m_last = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_ferr = 1'b0;
    int         cyc = 0;
    int         busy_from = 0;
    int         busy_to = 0;
    bit         run_checks = 1'b0;
    int         ferr_seen = 0;

    bit         m_pop, m_push, m_fe, m_set;
    ev_t        m_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Receive model: bytes land at their stop-sample cycle, pops follow out_ready.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            exp_q.delete();
            pend.delete();
            m_last    = 8'h00;
            m_ovf     = 1'b0;
            m_ferr    = 1'b0;
            busy_from = 0;
            busy_to   = 0;
        end else begin
            cyc++;
            m_pop  = out_ready && (exp_q.size() > 0);
            m_push = 1'b0;
            m_fe   = 1'b0;
            m_set  = 1'b0;
            if (pend.size() > 0 && pend[0].at == cyc) begin
                m_ev = pend.pop_front();
                if (m_ev.good) m_push = 1'b1;
                else           m_fe   = 1'b1;
            end
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(m_ev.b);
                else                      m_set = 1'b1;
            end
            if (m_set)             m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
            if (exp_q.size() > 0) m_last = exp_q[0];
            m_ferr = m_fe;
        end
    end

    initial forever begin
        @(posedge clk);
        #3;
        if (run_checks) begin
            check("out_valid",   out_valid,   exp_q.size() != 0);
            check("level",       level,       exp_q.size());
            check("out_data",    out_data,    m_last);
            check("overflow",    overflow,    m_ovf);
            check("framing_err", framing_err, m_ferr);
            check("busy",        busy,        (cyc >= busy_from) && (cyc < busy_to));
            if (framing_err) ferr_seen++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good_stop, input int high_after);
        int  p;
        ev_t ev;
        @(negedge clk);
        p = cyc;
        ev.at = p + PUSH_LAT;
        ev.b = b;
        ev.good = good_stop;
        pend.push_back(ev);
        busy_from = p + 3;
        busy_to   = good_stop ? p + PUSH_LAT : p + high_after + 3;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (good_stop) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (high_after - 9 * CPB) @(negedge clk);
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic glitch(input int len);
        int p;
        @(negedge clk);
        p = cyc;
        busy_from = p + 3;
        busy_to   = p + 3 + CPB / 2;
        rx = 1'b0;
        repeat (len) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic pop_n(input int n);
        repeat (n) begin
            @(negedge clk);
            popped.push_back(out_data);
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic reset_mid_frame(input logic [7:0] b);
        int  p;
        ev_t ev;
        @(negedge clk);
        p = cyc;
        ev.at = p + PUSH_LAT;
        ev.b = b;
        ev.good = 1'b1;
        pend.push_back(ev);
        busy_from = p + 3;
        busy_to   = p + PUSH_LAT;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[4];
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy",  busy,  1'b0);
        check("rst_mid_level", level, 0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: stuck at %0t, 0 expected", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit         good;
        int         mode;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid",   out_valid,   1'b0);
        check("rst_level",       level,       0);
        check("rst_busy",        busy,        1'b0);
        check("rst_overflow",    overflow,    1'b0);
        check("rst_framing_err", framing_err, 1'b0);
        check("rst_out_data",    out_data,    8'h00);
        check("rst_state",       dbg_state,   3'd0);
        run_checks = 1'b1;
        reset_n = 1'b1;
        idle(10);

        send_frame(8'hA5, 1'b1, 0);
        idle(5);
        check("a5_data",  out_data,  8'hA5);
        check("a5_valid", out_valid, 1'b1);
        check("a5_level", level,     1);
        check("a5_ferr",  ferr_seen, 0);
        popped.delete();
        pop_n(1);
        check("a5_pop", popped[0], 8'hA5);

        glitch(5);
        check("glitch_level", level,     0);
        check("glitch_ferr",  ferr_seen, 0);
        check("glitch_busy",  busy,      1'b0);

        send_frame(8'h3C, 1'b0, 11 * CPB);
        idle(10);
        check("ferr_count", ferr_seen, 1);
        check("ferr_level", level,     0);
        send_frame(8'h55, 1'b1, 0);
        idle(5);
        check("after_ferr_data", out_data, 8'h55);
        popped.delete();
        pop_n(1);
        check("after_ferr_pop", popped[0], 8'h55);

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 0);
        idle(5);
        check("ovf_level", level,    8);
        check("ovf_flag",  overflow, 1'b1);
        popped.delete();
        pop_n(8);
        for (int i = 0; i < 8; i++) check("ovf_order", popped[i], 32'(i + 1));
        @(negedge clk) clr_overflow = 1'b1;
        @(negedge clk) clr_overflow = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        for (int i = 0; i < 8; i++) send_frame(8'hB0 + 8'(i), 1'b1, 0);
        idle(5);
        check("full_level", level, 8);
        fork
            send_frame(8'h77, 1'b1, 0);
            begin
                repeat (PUSH_LAT) @(negedge clk);
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        idle(5);
        check("pushpop_level", level,    8);
        check("pushpop_ovf",   overflow, 1'b0);
        popped.delete();
        pop_n(8);
        check("pushpop_first", popped[0], 8'hB1);
        check("pushpop_last",  popped[7], 8'h77);

        send_frame(8'h9C, 1'b1, 0);
        idle(5);
        check("pre_rst_level", level, 1);
        reset_mid_frame(8'hFF);
        idle(20);
        send_frame(8'h12, 1'b1, 0);
        idle(5);
        check("post_rst_data",  out_data, 8'h12);
        check("post_rst_level", level,    1);
        popped.delete();
        pop_n(1);
        check("post_rst_pop", popped[0], 8'h12);

        repeat (24) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 7) != 0);
            mode = $urandom_range(0, 2);
            fork
                send_frame(b, good, good ? 0 : $urandom_range(10 * CPB, 12 * CPB));
                begin
                    repeat (9 * CPB) begin
                        @(negedge clk);
                        out_ready    = (mode != 0) && ($urandom_range(0, 7) == 0);
                        clr_overflow = ($urandom_range(0, 15) == 0);
                    end
                    @(negedge clk);
                    out_ready    = 1'b0;
                    clr_overflow = 1'b0;
                end
            join
            idle($urandom_range(0, 20));
        end

        @(negedge clk) out_ready = 1'b1;
        idle(DEPTH + 2);
        out_ready = 1'b0;
        idle(3);
        check("drain_level", level, 0);

        run_checks = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
